// File: rtl/input_x_fetcher.sv
// Streams one sequence of LSTM input vectors out of a combinational-read ROM.
// The block loads NUM words per timestep and then holds the vector until the datapath accepts it.
module input_x_fetcher #(
    parameter int WIDTH          = 32,
    parameter int NUM            = 45,
    parameter int NUM_ITERATIONS = 8,
    parameter int NUM_SEQ        = 2,
    parameter int SEQ_W          = 1,
    parameter int T_W            = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEQ_W-1:0]     seq_sel,
    output logic [WIDTH-1:0]     mem_addr,
    input  logic [WIDTH-1:0]     mem_data,
    output logic [WIDTH*NUM-1:0] x_out,
    output logic                 x_valid,
    input  logic                 x_ready,
    output logic [T_W-1:0]       t_idx,
    output logic                 x_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IW-1:0]  I_LAST = IW'(NUM - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(NUM_ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, DONE} state_t;

    state_t                   state, state_nx;
    logic [SEQ_W-1:0]         seq_q;
    logic [T_W-1:0]           t_q;
    logic [IW-1:0]            i_q;
    logic [NUM-1:0][WIDTH-1:0] xbuf;
    logic [WIDTH-1:0]         addr_q, addr_ld;
    logic                     err_q;
    logic                     seq_legal;

    assign seq_legal = (32'(seq_sel) < 32'(NUM_SEQ));
    assign addr_ld   = (WIDTH'(seq_q) * WIDTH'(NUM_ITERATIONS) + WIDTH'(t_q)) * WIDTH'(NUM)
                     + WIDTH'(i_q);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start && seq_legal) state_nx = LOAD;
            LOAD:    if (i_q == I_LAST) state_nx = PRESENT;
            PRESENT: if (x_ready) state_nx = (t_q == T_LAST) ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        x_valid  = (state == PRESENT);
        x_last   = (state == PRESENT) && (t_q == T_LAST);
        busy     = (state == LOAD) || (state == PRESENT);
        done     = (state == DONE);
        err      = err_q;
        t_idx    = t_q;
        x_out    = xbuf;
        mem_addr = '0;
        // Address is live during LOAD; afterwards it holds the last word fetched.
        case (state)
            LOAD:          mem_addr = addr_ld;
            PRESENT, DONE: mem_addr = addr_q;
            default:       mem_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            seq_q  <= '0;
            t_q    <= '0;
            i_q    <= '0;
            xbuf   <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == IDLE) && start && !seq_legal;
            case (state)
                IDLE: begin
                    if (start && seq_legal) begin
                        seq_q <= seq_sel;
                        t_q   <= '0;
                        i_q   <= '0;
                    end
                end
                LOAD: begin
                    xbuf[i_q] <= mem_data;
                    addr_q    <= addr_ld;
                    i_q       <= (i_q == I_LAST) ? '0 : i_q + IW'(1);
                end
                PRESENT: begin
                    if (x_ready && (t_q != T_LAST)) t_q <= t_q + T_W'(1);
                end
                DONE: t_q <= '0;
                default: ;
            endcase
        end
    end
endmodule
